uart_host_bridge: RTL and testbench
===================================

Name: uart_host_bridge

Overview:
Host-side companion to uart_core. It drives the core's transmit interface and drains its receive interface.
- Buffers outbound bytes in a TX FIFO and issues single-cycle tx_start pulses in step with tx_busy.
- Captures received bytes, each tagged with an error flag, into an RX FIFO.
- Generates the baud16_en strobe from a programmable divisor.
- Sits between the host logic (valid/ready streams) and uart_core.

Parameters:
FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2.
DIV_W, 16, width of the baud divisor.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
baud_div  in  DIV_W  baud16_en period minus 1, in clk cycles
baud16_en  out  1  one-cycle 16x baud strobe, to uart_core
wr_valid  in  1  host byte to transmit is valid
wr_data  in  8  host byte to transmit
wr_ready  out  1  TX FIFO not full
rd_valid  out  1  RX FIFO not empty
rd_data  out  8  head-of-RX-FIFO byte
rd_err  out  1  error flag stored with rd_data
rd_ready  in  1  host pops RX head
core_tx_data  out  8  to uart_core tx_data
core_tx_start  out  1  to uart_core tx_start
core_tx_busy  in  1  from uart_core tx_busy
core_rx_data  in  8  from uart_core rx_data
core_rx_ready  in  1  from uart_core rx_ready (one-cycle pulse)
core_rx_error  in  1  from uart_core rx_error
tx_level  out  clog2(FIFO_DEPTH)+1  TX FIFO occupancy
rx_overrun  out  1  sticky: RX byte dropped because the RX FIFO was full
clr_overrun  in  1  clears rx_overrun

Behaviour:
Reset values:
- baud16_en=0, core_tx_start=0, core_tx_data=0, wr_ready=1, rd_valid=0, rd_data=0, rd_err=0, tx_level=0, rx_overrun=0.
- Both FIFOs empty, baud counter 0, TX FSM in T_IDLE.
- Reset mid-frame aborts everything and discards FIFO contents. No tx_start is issued until reset is released.

Baud generator:
- Counter cnt increments every clk.
- When cnt >= baud_div: baud16_en=1 for that cycle (registered output) and cnt returns to 0.
- baud_div=0 gives baud16_en high every cycle. baud_div=N gives period N+1.
- If baud_div is lowered below cnt, a pulse is emitted on the next cycle (>= compare).

TX FIFO:
- Push when wr_valid && wr_ready. wr_ready = (level != FIFO_DEPTH).
- Pop is internal, driven by the TX FSM.
- Simultaneous push and pop at any level leaves the level unchanged.

TX FSM, states T_IDLE, T_WAIT_BUSY, T_WAIT_DONE:
- T_IDLE: if FIFO non-empty and core_tx_busy=0:
  - register core_tx_data = head and core_tx_start=1 (exactly one cycle);
  - pop;
  - go to T_WAIT_BUSY.
- T_WAIT_BUSY: core_tx_start=0. When core_tx_busy=1, go to T_WAIT_DONE.
- T_WAIT_DONE: when core_tx_busy=0, go to T_IDLE.
- core_tx_data holds its value until the next start.
- Minimum gap from busy falling to the next start: 1 cycle.

RX path:
- err_acc sets whenever core_rx_error=1. It is needed because the core clears its error on the same edge it raises rx_ready.
- On core_rx_ready=1:
  - push {err_acc | core_rx_error, core_rx_data};
  - clear err_acc.
- If the RX FIFO is full when core_rx_ready=1: byte is dropped, rx_overrun set to 1, err_acc still cleared.
- Simultaneous host pop (rd_valid && rd_ready) and core_rx_ready when full: the pop frees space, so the push is accepted and no overrun is flagged.
- rd_data/rd_err present the FIFO head combinationally from FIFO storage (first-word fall-through). Read latency from push to rd_valid = 1 cycle.
- clr_overrun clears rx_overrun. If clr_overrun and a new overrun occur in the same cycle, the set wins.

Pointers:
- Pointers have clog2(FIFO_DEPTH)+1 bits and wrap naturally.
- full = pointers differ only in MSB; empty = pointers equal.

Decomposition:
- Package uart_pkg: FSM state encoding (T_IDLE=0, T_WAIT_BUSY=1, T_WAIT_DONE=2), and default FIFO_DEPTH and DIV_W constants.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - ports clk, rst, push, push_data, pop, pop_data, full, empty, level;
  - first-word fall-through;
  - instantiated twice: WIDTH=8 for TX, WIDTH=9 for RX.
- Baud generator and TX FSM stay in the top module.

Test Plan:
1. baud_div=3, run 20 cycles -> baud16_en high on exactly every 4th cycle (5 pulses). Then baud_div=0 -> high every cycle.
2. Push 0x55, 0xA3, 0x0F with a core model (busy rises 1 cycle after start, held 10 cycles) -> three single-cycle starts with core_tx_data 0x55, 0xA3, 0x0F in order; no start while busy=1; tx_level goes 3→0.
3. Push 9 bytes with FIFO_DEPTH=8 and core busy held high -> wr_ready=0 after the 8th; tx_level=8; the 9th is not accepted until the first start.
4. Pulse core_rx_error 3 cycles before core_rx_ready with data 0x7E, then a clean 0x81 -> rd sequence {err=1,0x7E}, {err=0,0x81}.
5. Inject 9 rx_ready pulses with rd_ready=0 -> 8 entries stored, rx_overrun=1, 9th byte lost. clr_overrun -> 0. rx_ready and rd_ready in the same cycle while full -> accepted, no overrun.
6. Assert rst while in T_WAIT_DONE with 4 bytes queued -> all outputs return to reset values; after release, no core_tx_start until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared TX state encoding and default sizes for the UART host bridge
package uart_pkg;
    typedef enum logic [1:0] {
        T_IDLE      = 2'd0,
        T_WAIT_BUSY = 2'd1,
        T_WAIT_DONE = 2'd2
    } tx_state_t;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int DIV_W_DEF = 16;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign level = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];
    assign do_pop = pop && !empty;
    // a same-cycle pop frees the slot being written, so a full FIFO still accepts
    assign do_push = push && (!full || pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/uart_host_bridge.sv
// uart_host_bridge: host-side FIFO buffering, baud strobe and TX sequencing for uart_core
module uart_host_bridge
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DIV_W-1:0]             baud_div,
    output logic                         baud16_en,
    input  logic                         wr_valid,
    input  logic [7:0]                   wr_data,
    output logic                         wr_ready,
    output logic                         rd_valid,
    output logic [7:0]                   rd_data,
    output logic                         rd_err,
    input  logic                         rd_ready,
    output logic [7:0]                   core_tx_data,
    output logic                         core_tx_start,
    input  logic                         core_tx_busy,
    input  logic [7:0]                   core_rx_data,
    input  logic                         core_rx_ready,
    input  logic                         core_rx_error,
    output logic [$clog2(FIFO_DEPTH):0]  tx_level,
    output logic                         rx_overrun,
    input  logic                         clr_overrun
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    logic [DIV_W-1:0] cnt;
    tx_state_t state;
    logic [7:0] tx_head;
    logic [8:0] rx_head;
    logic [LW-1:0] rx_level;
    logic tx_full, tx_empty, tx_push, tx_pop;
    logic rx_full, rx_empty, rx_pop, err_acc;
    assign wr_ready = !tx_full;
    assign tx_push = wr_valid && wr_ready;
    assign tx_pop = state == T_IDLE && !tx_empty && !core_tx_busy;
    assign rd_valid = rx_level != '0;
    assign rx_pop = rd_ready && !rx_empty;
    assign {rd_err, rd_data} = rx_head;
    // >= compare so lowering baud_div below cnt still produces a prompt pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            baud16_en <= 1'b0;
        end else begin
            baud16_en <= cnt >= baud_div;
            cnt <= cnt >= baud_div ? '0 : cnt + DIV_W'(1);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T_IDLE;
            core_tx_start <= 1'b0;
            core_tx_data <= '0;
        end else begin
            core_tx_start <= tx_pop;
            if (tx_pop) core_tx_data <= tx_head;
            case (state)
                T_IDLE:      if (tx_pop) state <= T_WAIT_BUSY;
                T_WAIT_BUSY: if (core_tx_busy) state <= T_WAIT_DONE;
                T_WAIT_DONE: if (!core_tx_busy) state <= T_IDLE;
                default:     state <= T_IDLE;
            endcase
        end
    end
    // the core drops rx_error on the edge it raises rx_ready, so the flag is held here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_acc <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            err_acc <= core_rx_ready ? 1'b0 : err_acc | core_rx_error;
            rx_overrun <= (core_rx_ready && rx_full && !rx_pop) ? 1'b1 : (clr_overrun ? 1'b0 : rx_overrun);
        end
    end
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk),
        .rst(rst),
        .push(tx_push),
        .push_data(wr_data),
        .pop(tx_pop),
        .pop_data(tx_head),
        .full(tx_full),
        .empty(tx_empty),
        .level(tx_level)
    );
    sync_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk),
        .rst(rst),
        .push(core_rx_ready),
        .push_data({err_acc | core_rx_error, core_rx_data}),
        .pop(rx_pop),
        .pop_data(rx_head),
        .full(rx_full),
        .empty(rx_empty),
        .level(rx_level)
    );
endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge: queue-based reference model with per-cycle compare plus directed literal checks
module tb_uart_host_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] baud_div = 16'd3;
    logic wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic rd_ready = 1'b0;
    logic core_tx_busy = 1'b0;
    logic [7:0] core_rx_data = 8'h00;
    logic core_rx_ready = 1'b0;
    logic core_rx_error = 1'b0;
    logic clr_overrun = 1'b0;
    logic baud16_en, wr_ready, rd_valid, rd_err, core_tx_start, rx_overrun;
    logic [7:0] rd_data, core_tx_data;
    logic [3:0] tx_level;

    always #5 clk = ~clk;

    uart_host_bridge dut (
        .clk(clk), .rst(rst), .baud_div(baud_div), .baud16_en(baud16_en),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .rd_ready(rd_ready),
        .core_tx_data(core_tx_data), .core_tx_start(core_tx_start), .core_tx_busy(core_tx_busy),
        .core_rx_data(core_rx_data), .core_rx_ready(core_rx_ready), .core_rx_error(core_rx_error),
        .tx_level(tx_level), .rx_overrun(rx_overrun), .clr_overrun(clr_overrun)
    );

    int checks = 0;
    int failures = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: transmit queue, receive queue of {err,data}, and a start/busy handshake phase
    int m_cnt, m_phase;
    bit m_baud, m_start, m_err, m_ovr;
    logic [7:0] m_data;
    logic [7:0] tq[$];
    logic [8:0] rq[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_phase = 0; m_baud = 0; m_start = 0; m_err = 0; m_ovr = 0; m_data = 8'h00;
            tq.delete();
            rq.delete();
        end else begin
            bit tx_room, tx_go, rx_full, rx_go, ovf;
            m_baud = m_cnt >= int'(baud_div);
            m_cnt = m_baud ? 0 : m_cnt + 1;
            tx_room = tq.size() < 8;
            tx_go = m_phase == 0 && tq.size() > 0 && !core_tx_busy;
            m_start = tx_go;
            if (tx_go) begin
                m_data = tq.pop_front();
                m_phase = 1;
            end else if (m_phase == 1 && core_tx_busy) m_phase = 2;
            else if (m_phase == 2 && !core_tx_busy) m_phase = 0;
            if (wr_valid && tx_room) tq.push_back(wr_data);
            rx_full = rq.size() == 8;
            rx_go = rd_ready && rq.size() > 0;
            ovf = core_rx_ready && rx_full && !rx_go;
            if (rx_go) void'(rq.pop_front());
            if (core_rx_ready) begin
                if (!ovf) rq.push_back({m_err | core_rx_error, core_rx_data});
                m_err = 0;
            end else if (core_rx_error) m_err = 1;
            if (ovf) m_ovr = 1;
            else if (clr_overrun) m_ovr = 0;
        end
    end

    logic [7:0] starts[$];

    initial begin
        @(posedge clk);
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            if (core_tx_start) starts.push_back(core_tx_data);
            chk("baud16_en", baud16_en, m_baud);
            chk("core_tx_start", core_tx_start, m_start);
            chk("core_tx_data", core_tx_data, m_data);
            chk("tx_level", tx_level, tq.size());
            chk("wr_ready", wr_ready, tq.size() != 8);
            chk("rd_valid", rd_valid, rq.size() != 0);
            if (rq.size() != 0) begin
                chk("rd_data", rd_data, rq[0][7:0]);
                chk("rd_err", rd_err, rq[0][8]);
            end
            chk("rx_overrun", rx_overrun, m_ovr);
        end
    end

    // core stand-in: busy rises one cycle after a start and stays high for 10 cycles
    bit hold_busy = 0;
    int pend = 0;
    int left = 0;
    always @(negedge clk) begin
        if (rst) begin
            pend = 0;
            left = 0;
        end else begin
            if (left > 0) left--;
            if (pend != 0) begin
                left = 10;
                pend = 0;
            end
            if (core_tx_start) pend = 1;
        end
        core_tx_busy = hold_busy || left > 0;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int cnt, s0;
        logic [7:0] last;
        tick(2);
        #1 rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            cnt += int'(baud16_en);
        end
        chk("baud_pulses_div3", cnt, 5);
        baud_div = 16'd0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(baud16_en);
        end
        chk("baud_pulses_div0", cnt, 5);
        baud_div = 16'd7;

        hold_busy = 1;
        tick(2);
        s0 = starts.size();
        wr_valid = 1'b1;
        wr_data = 8'h55; tick();
        wr_data = 8'hA3; tick();
        wr_data = 8'h0F; tick();
        wr_valid = 1'b0;
        chk("tx_level_3", tx_level, 3);
        hold_busy = 0;
        for (int k = 0; k < 100 && starts.size() - s0 < 3; k++) tick();
        tick(15);
        chk("tx_starts_n3", starts.size() - s0, 3);
        chk("tx_start0", starts[s0], 8'h55);
        chk("tx_start1", starts[s0+1], 8'hA3);
        chk("tx_start2", starts[s0+2], 8'h0F);
        chk("tx_level_drained", tx_level, 0);

        baud_div = 16'd2;
        hold_busy = 1;
        tick(2);
        s0 = starts.size();
        wr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_data = 8'(8'h30 + i);
            tick();
        end
        chk("wr_ready_full", wr_ready, 0);
        chk("tx_level_full", tx_level, 8);
        wr_data = 8'h38;
        tick(3);
        chk("tx_level_hold", tx_level, 8);
        chk("no_start_while_busy", starts.size() - s0, 0);
        hold_busy = 0;
        for (int k = 0; k < 20 && !wr_ready; k++) tick();
        tick();
        wr_valid = 1'b0;
        chk("starts_before_9th", starts.size() - s0, 1);
        for (int k = 0; k < 400 && (tx_level != 0 || core_tx_busy); k++) tick();
        tick(15);
        chk("tx_starts_n9", starts.size() - s0, 9);
        for (int i = 0; i < 9; i++) chk("tx_start_order", starts[s0+i], 8'(8'h30 + i));

        core_rx_error = 1'b1; tick();
        core_rx_error = 1'b0; tick(2);
        core_rx_data = 8'h7E; core_rx_ready = 1'b1; tick();
        core_rx_ready = 1'b0;
        chk("rx0_valid", rd_valid, 1);
        chk("rx0_data", rd_data, 8'h7E);
        chk("rx0_err", rd_err, 1);
        tick(2);
        core_rx_data = 8'h81; core_rx_ready = 1'b1; tick();
        core_rx_ready = 1'b0;
        rd_ready = 1'b1; tick();
        rd_ready = 1'b0;
        chk("rx1_data", rd_data, 8'h81);
        chk("rx1_err", rd_err, 0);
        rd_ready = 1'b1; tick();
        rd_ready = 1'b0;
        chk("rx_empty", rd_valid, 0);

        for (int i = 0; i < 9; i++) begin
            core_rx_data = 8'(8'h10 + i);
            core_rx_ready = 1'b1;
            tick();
        end
        core_rx_ready = 1'b0;
        chk("overrun_set", rx_overrun, 1);
        chk("rx_head_10", rd_data, 8'h10);
        clr_overrun = 1'b1; tick();
        clr_overrun = 1'b0;
        chk("overrun_clr", rx_overrun, 0);
        core_rx_data = 8'hEE; core_rx_ready = 1'b1; rd_ready = 1'b1; tick();
        core_rx_ready = 1'b0; rd_ready = 1'b0;
        chk("full_pop_push_no_overrun", rx_overrun, 0);
        chk("rx_head_11", rd_data, 8'h11);
        core_rx_data = 8'h99; core_rx_ready = 1'b1; clr_overrun = 1'b1; tick();
        core_rx_ready = 1'b0; clr_overrun = 1'b0;
        chk("overrun_set_wins", rx_overrun, 1);
        clr_overrun = 1'b1; tick();
        clr_overrun = 1'b0;
        last = 8'h00;
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            last = rd_data;
            tick();
        end
        rd_ready = 1'b0;
        chk("rx_tail_EE", last, 8'hEE);
        chk("rx_drained", rd_valid, 0);

        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'h61 + i);
            tick();
        end
        wr_valid = 1'b0;
        for (int k = 0; k < 20 && !core_tx_busy; k++) tick();
        tick(3);
        chk("tx_level_4", tx_level, 4);
        #1 rst = 1'b1;
        tick();
        chk("rst_baud16_en", baud16_en, 0);
        chk("rst_core_tx_start", core_tx_start, 0);
        chk("rst_core_tx_data", core_tx_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_err", rd_err, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_overrun", rx_overrun, 0);
        tick();
        #1 rst = 1'b0;
        s0 = starts.size();
        tick(30);
        chk("no_start_after_reset", starts.size() - s0, 0);
        wr_valid = 1'b1; wr_data = 8'h77; tick();
        wr_valid = 1'b0;
        tick(20);
        chk("start_after_reset_n", starts.size() - s0, 1);
        chk("start_after_reset_data", starts[starts.size()-1], 8'h77);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
